// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_types
// Description : Shared types for the memory port arbiter. Holds the request
//               record stored in each pending slot, the arbiter state
//               encoding and a helper that turns a cpu-side request into
//               the word-aligned command driven onto the shared memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

  // One memory request as seen on either cpu channel.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SRV_I = 2'd1,
    SRV_D = 2'd2
  } arb_state_t;

  localparam int unsigned C_STREAK_W = 4;

  // Memory-side view of a request: the address is word aligned, and a
  // store (nonzero wmask) suppresses the read mask entirely. Write data is
  // only carried for stores so reads present a clean all-zero wdata.
  function automatic mem_req_t to_mem_cmd(input mem_req_t req);
    mem_req_t cmd;
    cmd      = '0;
    cmd.addr = {req.addr[31:2], 2'b00};
    if (|req.wmask) begin
      cmd.wmask = req.wmask;
      cmd.wdata = req.wdata;
    end else begin
      cmd.rmask = req.rmask;
    end
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_req_slot.sv
`default_nettype none
// ============================================================================
// Module      : req_slot
// Description : Single-entry pending register for one cpu channel. The entry
//               stays valid from capture until its memory response pulses,
//               covering both the waiting and the in-flight phase.
// Ports       : clk        - clock
//               rst        - asynchronous reset, active low
//               req_i      - channel presents a request this cycle
//               req_data_i - request contents
//               done_i     - response pulse for this channel's transaction
//               valid_o    - entry occupied
//               capture_o  - request is being accepted at this edge
//               drop_o     - request arrived while occupied and not finishing
//               data_o     - stored request
// Revision    : 1.0 - initial release
// ============================================================================
module req_slot
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req_i,
  input  mem_req_t req_data_i,
  input  logic     done_i,
  output logic     valid_o,
  output logic     capture_o,
  output logic     drop_o,
  output mem_req_t data_o
);

  logic     valid_q, valid_d;
  mem_req_t data_q,  data_d;

  // A completing entry frees in the same edge, so a back-to-back request on
  // the response cycle is accepted without a gap.
  assign capture_o = req_i && (!valid_q || done_i);
  assign drop_o    = req_i && valid_q && !done_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (capture_o) begin
      valid_d = 1'b1;
      data_d  = req_data_i;
    end else if (done_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Serialises the cpu imem and dmem request channels onto one
//               shared multi-cycle memory port. Requests are latched so the
//               cpu may drop them after a single cycle; arbitration favours
//               one channel with a streak limit that protects the other.
// Ports       : clk, rst (async, active low)
//               imem_addr/rmask in, imem_rdata/resp out
//               dmem_addr/rmask/wmask/wdata in, dmem_rdata/resp out
//               mem_addr/rmask/wmask/wdata out (registered), mem_rdata/resp in
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter bit          DMEM_FIRST = 1'b1,
  parameter int unsigned MAX_STREAK = 4      // legal 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  localparam logic [C_STREAK_W-1:0] C_MAX_STREAK = C_STREAK_W'(MAX_STREAK);
  localparam logic                  C_PRIO_DMEM  = DMEM_FIRST;

  arb_state_t            state_q,  state_d;
  logic [C_STREAK_W-1:0] streak_q, streak_d;
  mem_req_t              mem_q,    mem_d;

  mem_req_t w_imem_in, w_dmem_in;
  mem_req_t w_imem_slot, w_dmem_slot;
  logic     w_imem_req, w_dmem_req;
  logic     w_imem_valid, w_dmem_valid;
  logic     w_imem_capture, w_dmem_capture;
  logic     w_imem_drop, w_dmem_drop;
  logic     w_arbitrate;
  logic     w_cand_imem, w_cand_dmem;
  mem_req_t w_imem_cand, w_dmem_cand;
  logic     grant_dmem;

  assign w_imem_req = |imem_rmask;
  assign w_dmem_req = (|dmem_rmask) || (|dmem_wmask);

  assign w_imem_in = '{addr: imem_addr, rmask: imem_rmask, wmask: 4'h0, wdata: 32'h0};
  assign w_dmem_in = '{addr: dmem_addr, rmask: dmem_rmask, wmask: dmem_wmask, wdata: dmem_wdata};

  assign imem_resp  = mem_resp && (state_q == SRV_I);
  assign dmem_resp  = mem_resp && (state_q == SRV_D);
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  req_slot u_imem_slot (
    .clk        (clk),
    .rst        (rst),
    .req_i      (w_imem_req),
    .req_data_i (w_imem_in),
    .done_i     (imem_resp),
    .valid_o    (w_imem_valid),
    .capture_o  (w_imem_capture),
    .drop_o     (w_imem_drop),
    .data_o     (w_imem_slot)
  );

  req_slot u_dmem_slot (
    .clk        (clk),
    .rst        (rst),
    .req_i      (w_dmem_req),
    .req_data_i (w_dmem_in),
    .done_i     (dmem_resp),
    .valid_o    (w_dmem_valid),
    .capture_o  (w_dmem_capture),
    .drop_o     (w_dmem_drop),
    .data_o     (w_dmem_slot)
  );

  // A new grant can only be issued when the port is free or its current
  // transaction finishes this cycle.
  assign w_arbitrate = (state_q == IDLE) || mem_resp;

  // Slot entries count as candidates unless they are the in-flight one (which
  // is completing whenever we arbitrate). Requests captured at this edge
  // bypass the slot so an idle port is driven on the very next cycle.
  assign w_cand_imem = (w_imem_valid && (state_q != SRV_I)) || w_imem_capture;
  assign w_cand_dmem = (w_dmem_valid && (state_q != SRV_D)) || w_dmem_capture;
  assign w_imem_cand = w_imem_capture ? w_imem_in : w_imem_slot;
  assign w_dmem_cand = w_dmem_capture ? w_dmem_in : w_dmem_slot;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    mem_d      = mem_q;
    grant_dmem = 1'b0;
    if (w_arbitrate) begin
      if (w_cand_imem && w_cand_dmem) begin
        // Contention: the streak limit hands one grant to the waiting side.
        if (streak_q == C_MAX_STREAK) begin
          grant_dmem = !C_PRIO_DMEM;
          streak_d   = '0;
        end else begin
          grant_dmem = C_PRIO_DMEM;
          streak_d   = streak_q + 1'b1;
        end
      end else begin
        grant_dmem = w_cand_dmem;
        streak_d   = '0;
      end

      if (w_cand_imem || w_cand_dmem) begin
        state_d = grant_dmem ? SRV_D : SRV_I;
        mem_d   = to_mem_cmd(grant_dmem ? w_dmem_cand : w_imem_cand);
      end else begin
        state_d = IDLE;
        mem_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      mem_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      mem_q    <= mem_d;
    end
  end

  assign mem_addr  = mem_q.addr;
  assign mem_rmask = mem_q.rmask;
  assign mem_wmask = mem_q.wmask;
  assign mem_wdata = mem_q.wdata;

`ifndef SYNTHESIS
  // Protocol checks on the cpu and memory sides.
  a_imem_no_drop: assert property (@(posedge clk) disable iff (!rst) !w_imem_drop)
    else $error("imem request while slot busy was dropped");
  a_dmem_no_drop: assert property (@(posedge clk) disable iff (!rst) !w_dmem_drop)
    else $error("dmem request while slot busy was dropped");
  a_no_idle_resp: assert property (@(posedge clk) disable iff (!rst) !(mem_resp && state_q == IDLE))
    else $error("mem_resp while no transaction in flight");
`endif

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly downstream of the cpu top level. Takes its independent imem and dmem request ports and serializes them onto one shared, multi-cycle memory port.
- Latches each request so the cpu may drop it after one cycle. Arbitrates with dmem priority plus a starvation guard. Routes each memory response back to the channel that issued it.
- Lets the pipeline run against a single-ported memory model with no change to the cpu-side protocol.

Parameters:
- DMEM_FIRST, 1: 1 gives dmem priority when both channels are pending; 0 gives imem priority.
- MAX_STREAK, 4: maximum consecutive grants to the priority channel while the other channel waits. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- imem_addr  in  32  instruction fetch address
- imem_rmask  in  4  nonzero = fetch request this cycle
- imem_rdata  out  32  fetch data, valid when imem_resp=1
- imem_resp  out  1  one-cycle completion pulse
- dmem_addr  in  32  data address
- dmem_rmask  in  4  nonzero = load request
- dmem_wmask  in  4  nonzero = store request (takes precedence over rmask)
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data, valid when dmem_resp=1
- dmem_resp  out  1  one-cycle completion pulse
- mem_addr  out  32  word-aligned address, bits [1:0] = 00
- mem_rmask  out  4  read byte mask
- mem_wmask  out  4  write byte mask
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data
- mem_resp  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (rst=0, async): state=IDLE; both pending slots invalid; streak=0; all mem_* outputs=0; imem_resp=dmem_resp=0.
- Request capture:
  - A channel request is any cycle with a nonzero mask on that channel.
  - It is captured at the clock edge into that channel's pending slot (addr, masks, wdata).
  - Capture is allowed only if the slot is free, or if the slot's response is pulsing that same cycle.
  - A request arriving while the slot is busy and not completing is a protocol violation. It is dropped, and an assertion must fire.
- States:
  - IDLE: no memory transaction in flight.
  - SRV_I: an imem transaction is in flight.
  - SRV_D: a dmem transaction is in flight.
- Arbitration happens at each edge where state=IDLE, or where state=SRV_x with mem_resp=1.
  - Candidates are the pending slots not being completed, plus any request captured this edge (bypass).
  - Both candidates present: grant the priority channel, unless streak==MAX_STREAK, in which case grant the other channel.
  - One candidate: grant it. None: go to IDLE.
- Streak counter:
  - Increments on a priority-channel grant while the other channel is pending.
  - Resets to 0 on any other grant, and on entering IDLE.
- Memory drive:
  - mem_* outputs are registered and loaded on the grant edge.
  - They are held stable until the edge after mem_resp=1, then reloaded or cleared.
  - Store: mem_wmask=dmem_wmask, mem_rmask=0. Load/fetch: mem_rmask=mask, mem_wmask=0.
- Response:
  - imem_resp = mem_resp AND state==SRV_I; dmem_resp = mem_resp AND state==SRV_D. Both are combinational.
  - imem_rdata and dmem_rdata are both wired directly to mem_rdata.
  - The slot frees at that edge.
- Latency:
  - Request in cycle 0 with memory idle: mem request driven in cycle 1.
  - Memory with fixed latency L (mem_resp in cycle 1+L-1): cpu resp in the same cycle as mem_resp.
  - Back-to-back: the next grant drives mem in the cycle right after mem_resp, with no idle bubble.
- Reset mid-transaction: the in-flight transaction is abandoned and no resp pulses. The memory model is responsible for discarding it.
- mem_resp while IDLE: ignored, and an assertion must fire.

Decomposition:
- Shared package (rv32i_types): typedef mem_req_t {addr[31:0], rmask[3:0], wmask[3:0], wdata[31:0]}, and enum arb_state_t {IDLE, SRV_I, SRV_D}.
- One natural sub-module, req_slot: a single-entry pending register with capture/free control. It is instantiated twice, once per channel.

Test Plan:
- Single fetch: imem_rmask=F, addr=0x60000004 in cycle 0; memory latency 3 -> mem_rmask=F, mem_addr=0x60000004 from cycle 1; mem_resp=1, rdata=0x00000013 in cycle 3 -> imem_resp=1, imem_rdata=0x00000013 in cycle 3; mem_* = 0 in cycle 4.
- Simultaneous: imem 0x100 and dmem store (wmask=3, addr=0x202, wdata=0xBEEF) in cycle 0 -> store served first with mem_addr=0x200, mem_wmask=3; fetch driven in the cycle right after the store's mem_resp.
- Starvation: dmem issues back-to-back loads while one fetch is pending, MAX_STREAK=4 -> after 4 dmem grants, the next grant is imem; streak then resets.
- Same-channel reissue: new fetch in the exact cycle imem_resp=1 -> accepted and driven the next cycle. New fetch one cycle earlier -> dropped and assertion fires.
- Async reset: assert rst=0 mid-transaction (between edges) -> mem_rmask, mem_wmask and both resp go to 0 immediately. After release, no stale resp; a fresh request completes normally.
